mux_path_arbiter: RTL

//  Round-robin arbiter and sequencer for the shared 3-input Mux4_1 datapath.

---
 rtl/mux_arb_pkg.sv | 17 +
 rtl/rr_pick3.sv | 40 ++++
 rtl/mux_path_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the mux path arbiter.
package mux_arb_pkg;

    localparam int N_REQ = 3;

    // Mux4_1 selector encoding: three data inputs plus an idle code.
    localparam logic [1:0] SEL_IN0  = 2'd0;
    localparam logic [1:0] SEL_IN1  = 2'd1;
    localparam logic [1:0] SEL_IN2  = 2'd2;
    localparam logic [1:0] SEL_IDLE = 2'd3;

    // Next requester index with wrap: (ptr + 1) mod 3.
    function automatic logic [1:0] next_idx(input logic [1:0] ptr);
        return (ptr >= 2'd2) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way rotating priority picker. The requester just after
// ptr_i has the highest priority; ptr_i itself is scanned last.
module rr_pick3
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [1:0]       ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [1:0]       idx_o,
    output logic             any_o
);

    // Scan order: cand[0] is checked first, cand[N_REQ-1] (== ptr_i) last.
    logic [1:0] cand [N_REQ];

    assign cand[0] = next_idx(ptr_i);

    generate
        for (genvar gi = 1; gi < N_REQ; gi++) begin : g_cand
            assign cand[gi] = next_idx(cand[gi-1]);
        end
    endgenerate

    // Walk the scan order backwards so the earliest candidate wins.
    always_comb begin
        gnt_o = '0;
        idx_o = SEL_IDLE;
        any_o = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_i[cand[k]]) begin
                idx_o = cand[k];
                any_o = 1'b1;
            end
        end
        if (any_o) begin
            gnt_o = N_REQ'(1) << idx_o;
        end
    end

endmodule

// File: rtl/mux_path_arbiter.sv
// Round-robin arbiter for the shared 3-input result mux, with a 1-entry
// valid/ready output register. Optional owner locking is enabled by
// defining ARB_LOCK_EN; the default build is pure round-robin.
module mux_path_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_i,
    input  logic [N_REQ-1:0]  lock_i,
    input  logic [DATA_W-1:0] data0_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    output logic [N_REQ-1:0]  gnt_o,
    output logic [1:0]        sel_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;

    logic              can_accept;
    logic              grant;
    logic              lock_win;
    logic [N_REQ-1:0]  rr_gnt;
    logic [1:0]        rr_idx;
    logic              rr_any;
    logic [1:0]        win_idx;
    logic [DATA_W-1:0] mux_data;

    assign can_accept = !out_valid_q || out_ready_i;

    rr_pick3 u_pick (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx),
        .any_o (rr_any)
    );

`ifdef ARB_LOCK_EN
    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    // The current owner keeps the path while it locks and has budget left.
    assign lock_win = req_i[rr_ptr_q] && lock_i[rr_ptr_q]
                      && (hold_cnt_q < HOLD_W'(MAX_HOLD - 1));

    // Count grants won through the lock; any other grant restarts the count.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (grant) begin
            hold_cnt_d = lock_win ? hold_cnt_q + HOLD_W'(1) : '0;
        end
    end

    // Lock hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign lock_win = 1'b0;
    logic unused_lock_cfg;
    assign unused_lock_cfg = ^{lock_i, 32'(MAX_HOLD)};
`endif

    // Winner selection and grant outputs; no grant is shown while in reset.
    always_comb begin
        grant   = rst_n && can_accept && (rr_any || lock_win);
        win_idx = lock_win ? rr_ptr_q : rr_idx;
        gnt_o   = '0;
        sel_o   = SEL_IDLE;
        if (grant) begin
            gnt_o = lock_win ? (N_REQ'(1) << rr_ptr_q) : rr_gnt;
            sel_o = win_idx;
        end
    end

    // Mux4_1 datapath; the idle input is never captured.
    always_comb begin
        mux_data = '0;
        case (sel_o)
            SEL_IN0: mux_data = data0_i;
            SEL_IN1: mux_data = data1_i;
            SEL_IN2: mux_data = data2_i;
            default: mux_data = '0;
        endcase
    end

    // Output register next state: capture on grant, empty on a bare transfer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            rr_ptr_d    = win_idx;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; rr_ptr resets to 2 so requester 0 is first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rr_ptr_q    <= SEL_IN2;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule
